// File: rtl/gsim_pkg.sv
// Shared constants, state encoding and fixed-coefficient helpers for the Gauss-Seidel solver.
package gsim_pkg;

  localparam int unsigned N        = 16;
  localparam int unsigned ITER_DEF = 100;
  localparam int unsigned RECIP    = 52429;  // 1/20 as RECIP / 2^20
  localparam int unsigned SHIFT    = 20;
  localparam int unsigned B_W      = 16;
  localparam int unsigned X_W      = 32;
  localparam int unsigned ACC_W    = 40;
  localparam int unsigned PROD_W   = ACC_W + 18;
  localparam int unsigned IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StOut} state_e;

  function automatic logic signed [ACC_W-1:0] sext_x(input logic signed [X_W-1:0] v);
    return {{(ACC_W - X_W){v[X_W-1]}}, v};
  endfunction

  // Off-diagonal coefficients 13 and 6 as shift-add; the distance-3 coefficient is 1.
  function automatic logic signed [ACC_W-1:0] mul13(input logic signed [ACC_W-1:0] v);
    return (v <<< 3) + (v <<< 2) + v;
  endfunction

  function automatic logic signed [ACC_W-1:0] mul6(input logic signed [ACC_W-1:0] v);
    return (v <<< 2) + (v <<< 1);
  endfunction

endpackage

// File: rtl/gsim_update_unit.sv
// Combinational single-element Gauss-Seidel update: x_new = floor(sum * RECIP / 2^20).
module gsim_update_unit
  import gsim_pkg::*;
(
  input  logic signed [B_W-1:0] b,
  input  logic signed [X_W-1:0] xm1,
  input  logic signed [X_W-1:0] xp1,
  input  logic signed [X_W-1:0] xm2,
  input  logic signed [X_W-1:0] xp2,
  input  logic signed [X_W-1:0] xm3,
  input  logic signed [X_W-1:0] xp3,
  output logic signed [X_W-1:0] x_new
);

  logic signed [ACC_W-1:0]  b_sh, sum;
  logic signed [PROD_W-1:0] sum_ext, recip_ext, prod;
  logic                     unused_prod_bits;

  always_comb begin
    b_sh      = {{(ACC_W - B_W - 16){b[B_W-1]}}, b, 16'b0};
    sum       = b_sh
              + mul13(sext_x(xm1) + sext_x(xp1))
              - mul6(sext_x(xm2) + sext_x(xp2))
              + (sext_x(xm3) + sext_x(xp3));
    sum_ext   = {{(PROD_W - ACC_W){sum[ACC_W-1]}}, sum};
    recip_ext = PROD_W'(RECIP);
    prod      = sum_ext * recip_ext;
    // Taking bits above SHIFT of a signed product is an arithmetic (floor) shift.
    x_new     = prod[SHIFT +: X_W];
  end

  assign unused_prod_bits = ^{prod[SHIFT-1:0], prod[PROD_W-1:SHIFT+X_W]};

endmodule

// File: rtl/gsim_solver.sv
// 16-unknown banded Gauss-Seidel solver: serial b load, ITER in-place sweeps, serial x unload.
module gsim_solver
  import gsim_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic signed [B_W-1:0] b_in,
  output logic                  out_valid,
  output logic signed [X_W-1:0] x_out
);

  localparam int unsigned ITER_CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [ITER_CW-1:0] ITER_LAST = ITER_CW'(ITER - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [ITER_CW-1:0]   iter_q, iter_d;
  logic signed [B_W-1:0] b_q [N];
  logic signed [X_W-1:0] x_q [N];
  logic                 load_b, clear_x, upd_x, emit;
  logic signed [X_W-1:0] xm1, xp1, xm2, xp2, xm3, xp3, x_new;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    load_b  = 1'b0;
    clear_x = 1'b0;
    upd_x   = 1'b0;
    emit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_en) begin
          load_b  = 1'b1;
          cnt_d   = IDX_W'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (in_en) begin
          load_b = 1'b1;
          cnt_d  = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            clear_x = 1'b1;
            iter_d  = '0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        upd_x = 1'b1;
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          iter_d = iter_q + ITER_CW'(1);
          if (iter_q == ITER_LAST) begin
            iter_d  = '0;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        emit  = 1'b1;
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = StIdle;
      end
    endcase
  end

  // Neighbours outside 0..N-1 contribute zero.
  always_comb begin
    xm1 = '0;
    xp1 = '0;
    xm2 = '0;
    xp2 = '0;
    xm3 = '0;
    xp3 = '0;
    if (cnt_q >= IDX_W'(1))  xm1 = x_q[cnt_q - IDX_W'(1)];
    if (cnt_q >= IDX_W'(2))  xm2 = x_q[cnt_q - IDX_W'(2)];
    if (cnt_q >= IDX_W'(3))  xm3 = x_q[cnt_q - IDX_W'(3)];
    if (cnt_q <= IDX_W'(14)) xp1 = x_q[cnt_q + IDX_W'(1)];
    if (cnt_q <= IDX_W'(13)) xp2 = x_q[cnt_q + IDX_W'(2)];
    if (cnt_q <= IDX_W'(12)) xp3 = x_q[cnt_q + IDX_W'(3)];
  end

  gsim_update_unit u_update (
    .b     (b_q[cnt_q]),
    .xm1   (xm1),
    .xp1   (xp1),
    .xm2   (xm2),
    .xp2   (xp2),
    .xm3   (xm3),
    .xp3   (xp3),
    .x_new (x_new)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      iter_q    <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iter_q    <= iter_d;
      out_valid <= emit;
      if (load_b) b_q[cnt_q] <= b_in;
      if (clear_x) begin
        for (int i = 0; i < N; i++) x_q[i] <= '0;
      end else if (upd_x) begin
        x_q[cnt_q] <= x_new;
      end
      if (emit) x_out <= x_q[cnt_q];
    end
  end

endmodule

// File: tb/tb_gsim_solver.sv
// Scoreboard bench for gsim_solver: ITER=100 main instance plus an ITER=1 instance.
module tb_gsim_solver;

  localparam int ITER_MAIN = 100;
  localparam int LAT_MAIN  = ITER_MAIN * 16 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_en, in_en1;
  logic signed [15:0] b_in, b_in1;
  logic               out_valid, out_valid1;
  logic signed [31:0] x_out, x_out1;

  gsim_solver #(.ITER(ITER_MAIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .b_in      (b_in),
    .out_valid (out_valid),
    .x_out     (x_out)
  );

  gsim_solver #(.ITER(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en1),
    .b_in      (b_in1),
    .out_valid (out_valid1),
    .x_out     (x_out1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int b15_edge = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;
  int run_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit-exact reference of the in-place sweep.
  task automatic gs_model(input int b[16], input int iters, output int x[16]);
    longint s, p;
    for (int i = 0; i < 16; i++) x[i] = 0;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < 16; i++) begin
        s = longint'(b[i]) * 65536;
        if (i >= 1)  s += 13 * longint'(x[i-1]);
        if (i <= 14) s += 13 * longint'(x[i+1]);
        if (i >= 2)  s -= 6 * longint'(x[i-2]);
        if (i <= 13) s -= 6 * longint'(x[i+2]);
        if (i >= 3)  s += longint'(x[i-3]);
        if (i <= 12) s += longint'(x[i+3]);
        p = (s * 52429) >>> 20;
        x[i] = int'(p);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      run_len    = 0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) check_eq("latency", cyc - b15_edge, LAT_MAIN);
        run_len++;
        check_eq("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("x_out", longint'(x_out), longint'(exp_q.pop_front()));
      end else if (prev_valid) begin
        check_eq("run_len", run_len, 16);
        run_len = 0;
      end
      prev_valid = out_valid;
    end
  end

  // Called at a negedge; leaves the bench at a negedge.
  task automatic send(input int b[16], input bit pulses);
    int x[16];
    gs_model(b, ITER_MAIN, x);
    for (int i = 0; i < 16; i++) exp_q.push_back(x[i]);
    for (int i = 0; i < 16; i++) begin
      in_en = 1'b1;
      b_in  = 16'(b[i]);
      if (i == 15) b15_edge = cyc + 1;
      @(negedge clk);
    end
    in_en = 1'b0;
    if (pulses) begin
      repeat (40) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        in_en = 1'b1;
        b_in  = 16'(12345 + k);
        @(negedge clk);
      end
      in_en = 1'b0;
      repeat (700) @(negedge clk);
      in_en = 1'b1;
      b_in  = -16'sd7;
      @(negedge clk);
      in_en = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget = 3000;
    while ((exp_q.size() != 0 || out_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_vec(output int b[16]);
    for (int i = 0; i < 16; i++) b[i] = int'($urandom_range(65534)) - 32767;
  endtask

  initial begin
    int bz[16], bg[16], bp1[16], bp2[16], bp3[16], bp4[16], b1v[16], x1[16];
    int budget, run, seen;

    reset  = 1'b1;
    in_en  = 1'b0;
    in_en1 = 1'b0;
    b_in   = '0;
    b_in1  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_x_out", longint'(x_out), 0);
    check_eq("rst_valid1", out_valid1, 0);
    reset = 1'b0;
    @(negedge clk);

    // ITER=1 instance, unit impulse on b0.
    for (int i = 0; i < 16; i++) b1v[i] = 0;
    b1v[0] = 20;
    gs_model(b1v, 1, x1);
    for (int i = 0; i < 16; i++) begin
      in_en1 = 1'b1;
      b_in1  = 16'(b1v[i]);
      if (i == 15) b15_edge = cyc + 1;
      @(negedge clk);
    end
    in_en1 = 1'b0;
    budget = 100;
    while (!out_valid1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("i1_latency", cyc - b15_edge, 17);
    for (int k = 0; k < 16; k++) begin
      check_eq("i1_valid", out_valid1, 1);
      check_eq("i1_x", longint'(x_out1), longint'(x1[k]));
      if (k == 0) check_eq("i1_x0", longint'(x_out1), 65536);
      if (k == 1) check_eq("i1_x1", longint'(x_out1), 42598);
      if (k == 2) check_eq("i1_x2", longint'(x_out1), 8027);
      @(negedge clk);
    end
    check_eq("i1_valid_end", out_valid1, 0);

    // All-zero problem.
    for (int i = 0; i < 16; i++) bz[i] = 0;
    send(bz, 1'b0);
    wait_drain();

    // Graded pattern with extremes, plus stray in_en during CALC.
    for (int i = 0; i < 16; i++) bg[i] = ((i * 7919 + 1234) % 65535) - 32767;
    bg[3] = 32767;
    bg[9] = -32767;
    send(bg, 1'b1);
    wait_drain();

    // Back to back: second problem starts the cycle IDLE is re-entered.
    rand_vec(bp1);
    rand_vec(bp2);
    send(bp1, 1'b1);
    budget = 3000;
    run    = 0;
    while (run < 16 && budget > 0) begin
      @(negedge clk);
      budget--;
      run = out_valid ? run + 1 : 0;
    end
    check_eq("b2b_first_run", run, 16);
    send(bp2, 1'b0);
    wait_drain();

    // Reset mid-CALC aborts with no output.
    rand_vec(bp3);
    send(bp3, 1'b0);
    repeat (800) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("abort_no_valid", seen, 0);
    rand_vec(bp4);
    send(bp4, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
